// File: rtl/dma_pkg.sv
// dma_pkg: FSM state encoding shared by the read and write DMA engines
package dma_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} dma_state_e;
endpackage

// File: rtl/dma_writer.sv
// dma_writer: drains a snapshotted word buffer into consecutive memory words, one per clock
module dma_writer
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE       = 120,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]          i_address,
  input  logic [MEM_ADDRESS_WIDTH-1:0]          i_count,
  input  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] i_buffer,
  output logic [MEM_ADDRESS_WIDTH-1:0]          o_mem_addr,
  output logic [WORD_SIZE-1:0]                  o_mem_data,
  output logic                                  o_mem_write,
  output logic                                  o_busy,
  output logic                                  o_done
);
  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam logic [MEM_ADDRESS_WIDTH-1:0] MAX_CNT = MEM_ADDRESS_WIDTH'(BUFFER_SIZE);
  dma_state_e r_state, w_next;
  logic [MEM_ADDRESS_WIDTH-1:0] r_base, r_cnt, w_eff;
  logic [IDX_W-1:0] r_idx;
  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] r_snap;
  logic w_last;
  // Oversized requests are clamped so the index never runs past the snapshot
  assign w_eff  = i_count > MAX_CNT ? MAX_CNT : i_count;
  assign w_last = MEM_ADDRESS_WIDTH'(r_idx) == r_cnt - 1'b1;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE  ? (i_write ? (w_eff == '0 ? DONE : WRITE) : IDLE) :
             r_state == WRITE ? (w_last ? DONE : WRITE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_mem_write <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done      <= 1'b0;
          o_mem_write <= 1'b0;
          if (i_write) begin
            r_base <= i_address;
            r_cnt  <= w_eff;
            r_idx  <= '0;
            o_busy <= 1'b1;
          end
        end
        WRITE: begin
          o_mem_write <= 1'b1;
          o_mem_addr  <= r_base + MEM_ADDRESS_WIDTH'(r_idx);
          o_mem_data  <= r_snap[r_idx];
          r_idx       <= r_idx + IDX_W'(1);
        end
        DONE: begin
          o_mem_write <= 1'b0;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: o_mem_write <= 1'b0;
      endcase
    end
  end
  // Snapshot lets the producer reuse its buffer right after the request is accepted
  always_ff @(posedge clk)
    if (r_state == IDLE && i_write) r_snap <= i_buffer;
endmodule

// File: tb/tb_dma_writer.sv
// tb_dma_writer: directed checks of the write-back DMA against hand-derived expectations
module tb_dma_writer;
  localparam int BS = 120;
  localparam int WS = 16;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_write = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [AW-1:0] i_count = '0;
  logic [BS-1:0][WS-1:0] i_buffer;
  logic [AW-1:0] o_mem_addr;
  logic [WS-1:0] o_mem_data;
  logic o_mem_write, o_busy, o_done;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [AW-1:0] q_addr[$];
  logic [WS-1:0] q_data[$];
  int q_cyc[$];
  int n_done = 0;
  int done_cyc = 0;
  int n_busy = 0;
  int k, b_q, b_done, b_busy;

  dma_writer #(.BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_write(i_write), .i_address(i_address), .i_count(i_count),
    .i_buffer(i_buffer), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_write(o_mem_write), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_mem_write === 1'b1) begin
      q_addr.push_back(o_mem_addr);
      q_data.push_back(o_mem_data);
      q_cyc.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
    if (o_busy === 1'b1) n_busy = n_busy + 1;
  end

  function automatic logic [WS-1:0] w(input int i);
    return WS'(16'hA5C3 ^ (i * 16'h0107));
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic inv);
    for (int i = 0; i < BS; i++) i_buffer[i] = inv ? ~w(i) : w(i);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [AW-1:0] c);
    @(negedge clk);
    b_q = q_addr.size();
    b_done = n_done;
    b_busy = n_busy;
    i_address = a;
    i_count = c;
    i_write = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    i_write = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done == b_done && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_seen", int'(n_done != b_done), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_xfer(input string tag, input logic [AW-1:0] a, input int n);
    chk({tag, "_strobes"}, q_addr.size() - b_q, n);
    chk({tag, "_done_cnt"}, n_done - b_done, 1);
    chk({tag, "_done_cyc"}, done_cyc, k + n + 1);
    chk({tag, "_busy_cyc"}, n_busy - b_busy, n + 1);
    if (n > 0) chk({tag, "_first_cyc"}, q_cyc[b_q], k + 1);
    for (int i = 0; i < n && b_q + i < q_addr.size(); i++) begin
      chk({tag, "_addr"}, int'(q_addr[b_q + i]), int'(AW'(a + AW'(i))));
      chk({tag, "_data"}, int'(q_data[b_q + i]), int'(w(i)));
    end
  endtask

  initial begin
    fill(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_write", int'(o_mem_write), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_data", int'(o_mem_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // basic transfer of four words
    start(10'h010, 10'd4);
    chk("t1_busy_after_accept", int'(o_busy), 1);
    chk("t1_no_write_at_accept", int'(o_mem_write), 0);
    wait_done();
    check_xfer("t1", 10'h010, 4);
    chk("t1_hold_addr", int'(o_mem_addr), 32'h13);
    chk("t1_hold_data", int'(o_mem_data), int'(w(3)));
    chk("t1_busy_low", int'(o_busy), 0);
    // zero count
    start(10'h020, 10'd0);
    wait_done();
    check_xfer("t2", 10'h020, 0);
    // address wrap
    start(10'h3FE, 10'd4);
    wait_done();
    check_xfer("t3", 10'h3FE, 4);
    if (q_addr.size() >= b_q + 4) begin
      chk("t3_wrap0", int'(q_addr[b_q + 2]), 32'h000);
      chk("t3_wrap1", int'(q_addr[b_q + 3]), 32'h001);
    end
    // clamp to buffer size
    start(10'h100, 10'd200);
    wait_done();
    check_xfer("t4", 10'h100, 120);
    if (q_addr.size() > b_q) chk("t4_last_addr", int'(q_addr[q_addr.size() - 1]), 32'h177);
    // buffer changed after accept, second request mid-transfer
    start(10'h050, 10'd5);
    fill(1'b1);
    @(negedge clk);
    @(negedge clk);
    i_address = 10'h200;
    i_count = 10'd3;
    i_write = 1'b1;
    @(negedge clk);
    i_write = 1'b0;
    fill(1'b0);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    check_xfer("t5", 10'h050, 5);
    // reset mid-transfer
    start(10'h080, 10'd5);
    begin
      int t = 0;
      while (q_addr.size() - b_q < 2 && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
    end
    chk("t6_two_before_rst", q_addr.size() - b_q, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_write", int'(o_mem_write), 0);
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_addr", int'(o_mem_addr), 0);
    chk("t6_rst_data", int'(o_mem_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_more_strobes", q_addr.size() - b_q, 2);
    chk("t6_no_done", n_done - b_done, 0);
    start(10'h040, 10'd3);
    wait_done();
    check_xfer("t6b", 10'h040, 3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
